// File: rtl/uart_tx_link_ctrl.sv
// UART TX line-discipline controller: gates TX SM CTS, drives RTS and RS-485 DE.
// Optional `RXBLANK_EN adds RxEn, which blanks the receiver around DE for echo suppression.
module uart_tx_link_ctrl #(
    parameter int unsigned LEAD_BITS = 1,
    parameter int unsigned LAG_BITS  = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       CE_16x,
    input  logic [1:0] MD,
    input  logic       TF_EF,
    input  logic       TxIdle,
    input  logic       CTSi,
    output logic       TxCTS,
    output logic       RTSo,
    output logic       DE,
    output logic       Busy
`ifdef RXBLANK_EN
    ,
    output logic       RxEn
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XMIT  = 3'd2,
        DRAIN = 3'd3,
        LAG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LEAD_LOAD = (LEAD_BITS == 0) ? '0 : CNT_W'(LEAD_BITS * 16 - 1);
    localparam logic [CNT_W-1:0] LAG_LOAD  = (LAG_BITS  == 0) ? '0 : CNT_W'(LAG_BITS  * 16 - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       mdr;
    logic [1:0]       cts_sync;
    logic             txcts_d, rts_d, de_d, busy_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if ((state == LEAD || state == LAG) && CE_16x && cnt != '0)
            cnt_d = cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (mdr[1] && !TF_EF) begin
                    if (LEAD_BITS == 0) begin
                        state_d = XMIT;
                    end else begin
                        state_d = LEAD;
                        cnt_d   = LEAD_LOAD;
                    end
                end
            end
            LEAD: begin
                if (CE_16x && cnt == '0)
                    state_d = XMIT;
            end
            XMIT: begin
                if (TF_EF)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (!TF_EF) begin
                    state_d = XMIT;
                end else if (TxIdle) begin
                    if (LAG_BITS == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LAG;
                        cnt_d   = LAG_LOAD;
                    end
                end
            end
            LAG: begin
                if (!TF_EF)
                    state_d = XMIT;
                else if (CE_16x && cnt == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so the registered pins track the FSM exactly.
        de_d   = mdr[1] && (state_d != IDLE);
        busy_d = (state_d != IDLE);
        case (mdr)
            2'b00: begin
                txcts_d = 1'b1;
                rts_d   = 1'b0;
            end
            2'b01: begin
                txcts_d = cts_sync[1];
                rts_d   = !TF_EF || !TxIdle;
            end
            2'b10: begin
                txcts_d = (state_d == XMIT);
                rts_d   = 1'b0;
            end
            default: begin
                txcts_d = (state_d == XMIT);
                rts_d   = de_d;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mdr      <= '0;
            cts_sync <= '0;
            TxCTS    <= 1'b0;
            RTSo     <= 1'b0;
            DE       <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cts_sync <= {cts_sync[0], CTSi};
            // Mode only reloads when staying in IDLE, so a frame never starts under a new mode.
            if (state == IDLE && state_d == IDLE)
                mdr <= MD;
            TxCTS    <= txcts_d;
            RTSo     <= rts_d;
            DE       <= de_d;
            Busy     <= busy_d;
        end
    end

`ifdef RXBLANK_EN
    logic [4:0] blank, blank_d;

    // Blank counter is held full while DE is (or is about to stop being) high, then runs down one bit time.
    always_comb begin
        blank_d = blank;
        if (!mdr[1])
            blank_d = '0;
        else if (de_d || DE)
            blank_d = 5'd16;
        else if (CE_16x && blank != '0)
            blank_d = blank - 5'd1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            blank <= '0;
            RxEn  <= 1'b1;
        end else begin
            blank <= blank_d;
            RxEn  <= !de_d && (blank_d == '0);
        end
    end
`endif

endmodule
